// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_ctrl_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_RUN  = 2'b10,
    ST_FIX  = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply or restoring-divide on a 2*WIDTH work register.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the step result is registered.
module muldiv_iter
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic               i_div,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qbit
);

  // Multiply: upper half plus multiplicand when the current multiplier bit is set.
  logic [WIDTH:0]   w_sum;
  // Divide: partial remainder after shifting in the next dividend bit (WIDTH+1 bits).
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;

  assign w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
  assign w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge     = (w_rem_sh >= {1'b0, i_opnd});
  // When the subtraction succeeds the difference is below the divisor, so WIDTH bits hold it.
  assign w_rem_nx = w_ge ? (w_rem_sh[WIDTH-1:0] - i_opnd) : w_rem_sh[WIDTH-1:0];

  // Select the step flavour; for divide the quotient bit slot is left clear for the caller to merge.
  always_comb begin
    o_acc  = {w_sum, i_acc[WIDTH-1:1]};
    o_qbit = 1'b0;
    if (i_div) begin
      o_acc  = {w_rem_nx, i_acc[WIDTH-2:0], 1'b0};
      o_qbit = w_ge;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer with HI/LO registers; one bit per cycle, stalls the pipe on HI/LO hazards.
// Latency: start at edge E0 -> HI/LO written and done raised at E0+WIDTH+2.
// Backpressure: stall while busy and the pipe wants start/mfhi/mflo/mthi/mtlo; held writes land once idle.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_read,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e             r_state;
  op_e                r_op;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;   // raw b in PREP, then |b| for the whole run
  logic [WIDTH-1:0]   r_a;      // raw a, kept for the divide-by-zero HI value
  logic               r_sa;
  logic               r_sb;

  logic               w_is_div;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_step;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_acc_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_is_div = op_is_div(r_op);
  assign w_sa     = op_is_signed(r_op) & r_a[WIDTH-1];
  assign w_sb     = op_is_signed(r_op) & r_opnd[WIDTH-1];
  // Negating 0x80000000 yields 0x80000000, which read unsigned is the required 2^31.
  assign w_a_mag  = w_sa ? -r_a : r_a;
  assign w_b_mag  = w_sb ? -r_opnd : r_opnd;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_div  (w_is_div),
    .o_acc  (w_step),
    .o_qbit (w_qbit)
  );

  assign w_acc_nx = {w_step[2*WIDTH-1:1], w_step[0] | w_qbit};

  // Sign fix-up and HI/LO mapping of the finished magnitude result.
  always_comb begin
    w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
    w_quo    = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem    = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (w_is_div) begin
      if (r_opnd == '0) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  // Sequencer FSM with registered busy/done and the architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MULT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_a     <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        // Moves land only when idle; while busy the pipe is stalled and keeps them asserted.
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
        if (start && !cancel) begin
          r_state <= ST_PREP;
          r_busy  <= 1'b1;
          r_op    <= op_e'(op);
          r_a     <= a;
          r_opnd  <= b;
        end
      end else if (cancel) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_PREP: begin
            r_sa    <= w_sa;
            r_sb    <= w_sb;
            r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
            r_opnd  <= w_b_mag;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
          ST_RUN: begin
            r_acc <= w_acc_nx;
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign stall = r_busy & (start | hilo_read | hi_we | lo_we);
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer with architectural HI/LO registers. It sits beside the EX-stage ALU and executes mult, multu, div and divu at one bit per cycle. It services mthi/mtlo writes and produces the pipeline stall for HI/LO hazards. The main decoder supplies the op code and a start pulse; the hazard logic consumes stall.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a mul/div op this cycle (EX stage, not stalled)
op  in  2  00 mult, 01 multu, 10 div, 11 divu
a  in  WIDTH  rs operand / dividend
b  in  WIDTH  rt operand / divisor
cancel  in  1  pipeline flush; abort in-flight op
hi_we  in  1  mthi write request
lo_we  in  1  mtlo write request
wdata  in  WIDTH  mthi/mtlo data
hilo_read  in  1  mfhi/mflo present in ID
busy  out  1  operation in flight
done  out  1  one-cycle pulse; HI/LO hold new result
stall  out  1  freeze IF/ID/EX
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy, done, stall = 0; hi = lo = 0; counter and work registers = 0. Reset takes effect immediately, including mid-operation, and no partial result survives.
- FSM states: IDLE, PREP, RUN, FIX.
  - IDLE→PREP when start=1 and cancel=0.
  - PREP→RUN always.
  - RUN stays for WIDTH cycles (counter 0..WIDTH-1), then →FIX.
  - FIX→IDLE.
  - cancel=1 in any non-IDLE state: →IDLE next edge, HI/LO untouched, no done.
- Latency: start sampled at edge E0; busy=1 during cycles after E0..E34 (34 cycles). At E34 HI/LO are written and done=1 for exactly the following cycle, with busy=0 in that cycle. done is registered.
- PREP:
  - Latch op.
  - Signed ops: take magnitudes of a and b (0x80000000 magnitude treated as unsigned 2^31) and record result signs.
  - Unsigned ops: operands pass through.
- RUN, multiply: shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle, partial remainder WIDTH+1 bits.
- FIX, signs:
  - Product negated if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the sign of the dividend.
- Result mapping: mult puts the upper half in hi and the lower half in lo. div puts the quotient in lo and the remainder in hi.
- Divide by zero (div or divu): lo=all ones, hi=a unmodified. No exception raised.
- Overflow case 0x80000000 div 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo:
  - In IDLE: the write lands at the next edge.
  - When hi_we, lo_we and start occur in the same IDLE cycle: the write lands and the op starts. The op's result later overwrites HI/LO.
  - While busy: the write is held off by stall and lands at the first non-busy edge.
- stall = busy & (start | hilo_read | hi_we | lo_we). A start while busy is not accepted. stall is combinational from registered busy and inputs, and is 0 in the done cycle.
- A start in the done cycle is accepted normally (back-to-back).

Decomposition:
- Shared package holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - FSM state encoding
  - WIDTH default
- One natural sub-module, muldiv_iter: combinational single-step unit.
  - Inputs: accumulator/remainder, operand, mode.
  - Outputs: next accumulator/remainder and quotient bit.
- The FSM, counter, sign handling and HI/LO stay in muldiv_ctrl.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. busy for 34 cycles; done pulses one cycle at E34+.
- mult a=0xFFFFFFFD (-3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then div a=0xFFFFFFF9 (-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Issue the div in the done cycle to check back-to-back start.
- Boundary divides:
  - div a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu a=5 b=0 → lo=0xFFFFFFFF, hi=5.
- Hazard during an op:
  - hilo_read=1 from cycle 3 of an op → stall high until busy falls, 0 in the done cycle.
  - mthi wdata=0x1234 held while busy → hi=0x1234 after the op result is written.
- Cancel and reset mid-op:
  - Preload hi=0xAAAA via mthi, start div, cancel at RUN count 10 → busy=0 next cycle, hi=0xAAAA, no done.
  - rst_n low mid-RUN → all outputs 0 immediately, without waiting for a clock edge.
